// File: rtl/seg_pkg.sv
// Shared types and constants for the 3-digit 7-segment scan driver.
package seg_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a} (a = bit 0).
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg_scan_driver_hex.sv
// Combinational hex nibble to active-high 7-segment pattern lookup.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output logic [6:0]          o_seg
);

    assign o_seg = SEG7_HEX[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit 7-segment driver with inter-digit blanking,
// per-frame snapshot of the value and optional leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          lz_suppress,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] seg_value,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         dig_sel,
    output logic                          frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < BLANK_CYCLES + 2 || BLANK_CYCLES < 1) begin : g_bad_cfg
            $error("seg_scan_driver: DIV must be >= BLANK_CYCLES+2 and BLANK_CYCLES >= 1");
        end
    endgenerate

    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic          POL        = (ACTIVE_LOW != 0);
    localparam logic [6:0]    SEG_OFF    = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{POL}};

    state_t                          r_state;
    logic [CW-1:0]                   r_cnt;
    logic [1:0]                      r_idx;
    logic [NUM_DIGITS*NIBBLE_W-1:0]  r_frame;
    logic [6:0]                      r_seg;
    logic [NUM_DIGITS-1:0]           r_dig;
    logic                            r_fd;

    state_t                          w_state_nx;
    logic [CW-1:0]                   w_cnt_nx;
    logic [1:0]                      w_idx_nx;
    logic                            w_snap;
    logic [NUM_DIGITS*NIBBLE_W-1:0]  w_frame_nx;
    logic [NIBBLE_W-1:0]             w_nib;
    logic [6:0]                      w_seg7;
    logic                            w_blank;
    logic                            w_fd_nx;
    logic [6:0]                      w_seg_ah;
    logic [NUM_DIGITS-1:0]           w_dig_ah;

    // Next-state, slot counter and digit index; disable forces IDLE.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_idx;
        w_snap     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (enable) begin
                    w_state_nx = SHOW;
                    w_idx_nx   = 2'd0;
                    w_snap     = 1'b1;
                end
            end
            SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_state_nx = BLANK;
                    w_cnt_nx   = '0;
                end
            end
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nx = SHOW;
                    w_cnt_nx   = '0;
                    if (r_idx == 2'd2) begin
                        w_idx_nx = 2'd0;
                        w_snap   = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
                w_idx_nx   = 2'd0;
            end
        endcase
        if (!enable) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_idx_nx   = 2'd0;
            w_snap     = 1'b0;
        end
    end

    // The snapshot is taken on the same edge that enters digit 0, so the
    // outputs of that edge must already decode the incoming value.
    assign w_frame_nx = w_snap ? seg_value : r_frame;

    // Select the nibble for the digit being entered.
    always_comb begin
        w_nib = w_frame_nx[3:0];
        case (w_idx_nx)
            2'd1:    w_nib = w_frame_nx[7:4];
            2'd2:    w_nib = w_frame_nx[11:8];
            default: w_nib = w_frame_nx[3:0];
        endcase
    end

    hex_to_seg7 u_hex (
        .i_nibble (w_nib),
        .o_seg    (w_seg7)
    );

    // Leading-zero blanking: digit 0 always lit.
    assign w_blank = lz_suppress &&
                     (((w_idx_nx == 2'd2) && (w_frame_nx[11:8] == 4'h0)) ||
                      ((w_idx_nx == 2'd1) && (w_frame_nx[11:4] == 8'h00)));

    // Pulse lands on the final BLANK cycle of digit 2.
    assign w_fd_nx = (w_state_nx == BLANK) && (r_idx == 2'd2) && (w_cnt_nx == BLANK_LAST);

    // Active-high view of the outputs for the state being entered.
    always_comb begin
        w_seg_ah = 7'h00;
        w_dig_ah = '0;
        if (w_state_nx == SHOW && !w_blank) begin
            w_seg_ah = w_seg7;
            w_dig_ah = NUM_DIGITS'(1) << w_idx_nx;
        end
    end

    // State and registered outputs; polarity applied only here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_frame <= '0;
            r_seg   <= SEG_OFF;
            r_dig   <= DIG_OFF;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_frame <= w_frame_nx;
            r_seg   <= w_seg_ah ^ SEG_OFF;
            r_dig   <= w_dig_ah ^ DIG_OFF;
            r_fd    <= w_fd_nx;
        end
    end

    assign seg        = r_seg;
    assign dig_sel    = r_dig;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DIV=10, BLANK_CYCLES=2, active-low.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        lz_suppress;
    logic [11:0] seg_value;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;
    logic        frame_done;

    int vecs = 0;
    int errs = 0;

    // Active-low patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] OFF7 = 7'b1111111;
    localparam logic [2:0] D0 = 3'b110;
    localparam logic [2:0] D1 = 3'b101;
    localparam logic [2:0] D2 = 3'b011;
    localparam logic [2:0] DOFF = 3'b111;

    seg_scan_driver #(
        .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .lz_suppress(lz_suppress),
        .seg_value(seg_value), .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {seg, dig_sel, frame_done};
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed seg/dig/fd=%b required=%b", tag, obs, exp);
        end
    endtask

    // Entered at SHOW of a digit; checks 8 SHOW + 2 BLANK cycles and
    // returns positioned just after the edge entering the next slot.
    task automatic check_digit(input string tag, input logic [2:0] dig,
                               input logic [6:0] sg, input logic last);
        for (int i = 0; i < 10; i++) begin
            if (i < 8)       chk(tag, {sg, dig, 1'b0});
            else if (i == 8) chk(tag, {OFF7, DOFF, 1'b0});
            else             chk(tag, {OFF7, DOFF, last});
            step();
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; lz_suppress = 1'b0; seg_value = 12'h000;
        step(); step();
        chk("reset", {OFF7, DOFF, 1'b0});
        reset = 1'b0;
        step();
        chk("idle_disabled", {OFF7, DOFF, 1'b0});

        // 1: basic frame 123
        seg_value = 12'h123; enable = 1'b1;
        step();
        check_digit("t1_d0", D0, S3, 1'b0);
        check_digit("t1_d1", D1, S2, 1'b0);
        check_digit("t1_d2", D2, S1, 1'b1);

        // 2: change mid-frame is deferred to next frame
        check_digit("t2_d0", D0, S3, 1'b0);
        seg_value = 12'hABC;
        check_digit("t2_d1", D1, S2, 1'b0);
        check_digit("t2_d2", D2, S1, 1'b1);
        check_digit("t2_n_d0", D0, SC, 1'b0);
        check_digit("t2_n_d1", D1, SB, 1'b0);
        seg_value = 12'h005; lz_suppress = 1'b1;
        check_digit("t2_n_d2", D2, SA, 1'b1);

        // 3: leading-zero suppression on 005, then unsuppressed
        check_digit("t3_lz_d0", D0, S5, 1'b0);
        check_digit("t3_lz_d1", DOFF, OFF7, 1'b0);
        check_digit("t3_lz_d2", DOFF, OFF7, 1'b1);
        lz_suppress = 1'b0;
        check_digit("t3_nolz_d0", D0, S5, 1'b0);
        seg_value = 12'h000;
        check_digit("t3_nolz_d1", D1, S0, 1'b0);
        check_digit("t3_nolz_d2", D2, S0, 1'b1);

        // 4: all-zero value with suppression
        lz_suppress = 1'b1;
        check_digit("t4_d0", D0, S0, 1'b0);
        check_digit("t4_d1", DOFF, OFF7, 1'b0);
        check_digit("t4_d2", DOFF, OFF7, 1'b1);

        // 5: enable dropped mid-digit 1, re-enabled 5 cycles later
        seg_value = 12'h123; lz_suppress = 1'b0;
        check_digit("t5_d0", D0, S0, 1'b0);
        chk("t5_d1_show", {S0, D1, 1'b0});
        step(); step(); step();
        chk("t5_d1_mid", {S0, D1, 1'b0});
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_disabled", {OFF7, DOFF, 1'b0});
        end
        enable = 1'b1;
        step();
        check_digit("t5_re_d0", D0, S3, 1'b0);
        check_digit("t5_re_d1", D1, S2, 1'b0);
        check_digit("t5_re_d2", D2, S1, 1'b1);

        // 6: reset during SHOW of digit 2
        check_digit("t6_d0", D0, S3, 1'b0);
        check_digit("t6_d1", D1, S2, 1'b0);
        step(); step(); step();
        chk("t6_d2_mid", {S1, D2, 1'b0});
        reset = 1'b1;
        step();
        chk("t6_reset", {OFF7, DOFF, 1'b0});
        step();
        chk("t6_reset_hold", {OFF7, DOFF, 1'b0});
        reset = 1'b0;
        step();
        check_digit("t6_re_d0", D0, S3, 1'b0);
        check_digit("t6_re_d1", D1, S2, 1'b0);
        check_digit("t6_re_d2", D2, S1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
